// File: rtl/xor_mpm_rw.sv
// xor_mpm_rw: XOR-based multiport RAM with WR_PORTS write ports and RD_PORTS
// read ports. Each write port owns one bank and the logical word is the XOR of
// all banks. Writing port w stores wr_data ^ (other banks), so the XOR across
// banks yields wr_data. Each bank is replicated so that every reader has its
// own copy: one per other write port and one per read port.
//
// After reset the block sweeps zeros into every replica, one address per
// cycle. ready rises once the sweep completes.
//
// Optional build macro: XOR_MPM_RW_BYPASS_EN. When it is defined, reads bypass
// the in-flight stage-2 write, so a write is visible one cycle after it is
// accepted instead of two.
//
// Ports:
//   clk          clock, posedge
//   rst          synchronous active-high reset
//   wr_en[w]     write request, port w
//   wr_addr[w]   write address, port w
//   wr_data[w]   write data, port w
//   rd_en[r]     read request, port r
//   rd_addr[r]   read address, port r
//   rd_data[r]   registered read data, port r (holds when not reading)
//   rd_valid[r]  rd_data qualifier, one cycle after rd_en
//   ready        high once the zero sweep has completed
//   wr_conflict  one-cycle pulse after a same-address multi-port write
//
// state | meaning
// INIT  | zero sweep over all replicas, ports ignored
// RUN   | normal operation, ports serviced
module xor_mpm_rw #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 256,
  parameter  int WR_PORTS = 2,
  parameter  int RD_PORTS = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en       [WR_PORTS-1:0],
  input  logic [AW-1:0]    wr_addr     [WR_PORTS-1:0],
  input  logic [WIDTH-1:0] wr_data     [WR_PORTS-1:0],
  input  logic             rd_en       [RD_PORTS-1:0],
  input  logic [AW-1:0]    rd_addr     [RD_PORTS-1:0],
  output logic [WIDTH-1:0] rd_data     [RD_PORTS-1:0],
  output logic             rd_valid    [RD_PORTS-1:0],
  output logic             ready,
  output logic             wr_conflict
);

  localparam int NREP = WR_PORTS - 1 + RD_PORTS;

  typedef enum logic {INIT, RUN} state_e;

  state_e           state;
  logic [AW-1:0]    init_cnt;

  // mem[bank][replica][address]
  logic [WIDTH-1:0] mem [WR_PORTS][NREP][DEPTH];

  logic             wr_acc   [WR_PORTS];
  logic             wr_drop  [WR_PORTS];
  logic             conflict_any;
  logic [WIDTH-1:0] fb_next  [WR_PORTS];
  logic [WIDTH-1:0] rd_word  [RD_PORTS];

  logic             s2_en    [WR_PORTS];
  logic [AW-1:0]    s2_addr  [WR_PORTS];
  logic [WIDTH-1:0] s2_data  [WR_PORTS];
  logic [WIDTH-1:0] fb_q     [WR_PORTS];
  logic [WIDTH-1:0] s2_val   [WR_PORTS];

  // Replica of bank 'bank' dedicated to the feedback read of write port
  // 'reader' (reader != bank). Replicas NREP-RD_PORTS.. serve the read ports.
  function automatic int fb_copy(input int bank, input int reader);
    return (reader < bank) ? reader : reader - 1;
  endfunction

  // Value written into the bank in stage 2.
  always_comb begin
    for (int w = 0; w < WR_PORTS; w++) begin
      s2_val[w] = s2_data[w] ^ fb_q[w];
    end
  end

  // Same-address requests in one cycle: the highest-index port wins.
  always_comb begin
    conflict_any = 1'b0;
    for (int w = 0; w < WR_PORTS; w++) begin
      wr_acc[w]  = 1'b0;
      wr_drop[w] = 1'b0;
      if (state == RUN && wr_en[w]) begin
        wr_acc[w] = 1'b1;
        for (int u = w + 1; u < WR_PORTS; u++) begin
          if (wr_en[u] && wr_addr[u] == wr_addr[w]) begin
            wr_acc[w]  = 1'b0;
            wr_drop[w] = 1'b1;
          end
        end
      end
      conflict_any = conflict_any | wr_drop[w];
    end
  end

  // Stage-1 feedback: XOR of the other banks at the write address. A stage-2
  // write landing on the same word this cycle has not reached the RAM yet, so
  // its value is forwarded in place of the stale RAM output.
  always_comb begin
    logic [WIDTH-1:0] acc;
    for (int w = 0; w < WR_PORTS; w++) begin
      acc = '0;
      for (int v = 0; v < WR_PORTS; v++) begin
        if (v != w) begin
          if (s2_en[v] && s2_addr[v] == wr_addr[w]) begin
            acc = acc ^ s2_val[v];
          end else begin
            acc = acc ^ mem[v][fb_copy(v, w)][wr_addr[w]];
          end
        end
      end
      fb_next[w] = acc;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] acc;
    for (int r = 0; r < RD_PORTS; r++) begin
      acc = '0;
      for (int w = 0; w < WR_PORTS; w++) begin
`ifdef XOR_MPM_RW_BYPASS_EN
        if (s2_en[w] && s2_addr[w] == rd_addr[r]) begin
          acc = acc ^ s2_val[w];
        end else begin
          acc = acc ^ mem[w][WR_PORTS - 1 + r][rd_addr[r]];
        end
`else
        acc = acc ^ mem[w][WR_PORTS - 1 + r][rd_addr[r]];
`endif
      end
      rd_word[r] = acc;
    end
  end

  // Storage: every replica of bank w is written only by port w (or the sweep).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        for (int w = 0; w < WR_PORTS; w++) begin
          for (int c = 0; c < NREP; c++) begin
            mem[w][c][init_cnt] <= '0;
          end
        end
      end else begin
        for (int w = 0; w < WR_PORTS; w++) begin
          if (s2_en[w]) begin
            for (int c = 0; c < NREP; c++) begin
              mem[w][c][s2_addr[w]] <= s2_val[w];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
      for (int r = 0; r < RD_PORTS; r++) begin
        rd_valid[r] <= 1'b0;
        rd_data[r]  <= '0;
      end
      for (int w = 0; w < WR_PORTS; w++) begin
        s2_en[w]   <= 1'b0;
        s2_addr[w] <= '0;
        s2_data[w] <= '0;
        fb_q[w]    <= '0;
      end
    end else begin
      for (int w = 0; w < WR_PORTS; w++) begin
        s2_en[w]   <= wr_acc[w];
        s2_addr[w] <= wr_addr[w];
        s2_data[w] <= wr_data[w];
        fb_q[w]    <= fb_next[w];
      end
      wr_conflict <= conflict_any;
      for (int r = 0; r < RD_PORTS; r++) begin
        rd_valid[r] <= (state == RUN) && rd_en[r];
        if (state == RUN && rd_en[r]) begin
          rd_data[r] <= rd_word[r];
        end
      end
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == AW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/xor_mpm_rw.md
Name: xor_mpm_rw

Overview:
- Parametrised XOR-based multiport RAM with separate write ports (WR_PORTS) and read ports (RD_PORTS). It is the successor of the symmetric shared-address XOR memory.
- Adds the following over that block:
  - independent read and write port counts;
  - post-reset zero-initialisation sweep with a ready flag;
  - same-address write conflict resolution;
  - internal forwarding so that back-to-back writes from different ports are correct.
- Sits as the register-file/table store in multi-issue datapaths.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 256, number of words. Power of two, at least 2. AW = $clog2(DEPTH).
- WR_PORTS, 2, number of write ports, at least 1.
- RD_PORTS, 2, number of read ports, at least 1.

Ports:
- clk  in  1  single clock; all logic is on the posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1 [WR_PORTS-1:0] (unpacked)  write request per port.
- wr_addr  in  AW [WR_PORTS-1:0]  write address.
- wr_data  in  WIDTH [WR_PORTS-1:0]  write data.
- rd_en  in  1 [RD_PORTS-1:0]  read request per port.
- rd_addr  in  AW [RD_PORTS-1:0]  read address.
- rd_data  out  WIDTH [RD_PORTS-1:0]  read data, registered.
- rd_valid  out  1 [RD_PORTS-1:0]  rd_data qualifier.
- ready  out  1  high once initialisation is complete.
- wr_conflict  out  1  one-cycle pulse on a same-address write collision.

Behaviour:
- Storage organisation:
  - WR_PORTS banks, each DEPTH x WIDTH.
  - Bank w is replicated (WR_PORTS-1+RD_PORTS) times: one copy per feedback read from the other write ports, plus one copy per read port.
  - Every replica of bank w is written only by write port w.
  - Logical word at address A = XOR over all banks of bank[w][A].
- FSM states: INIT, RUN.
  - rst=1: next state INIT, init counter = 0, ready=0, rd_valid=0, rd_data=0, wr_conflict=0.
  - INIT:
    - every replica of every bank is written with 0 at address = counter; counter increments each cycle.
    - wr_en and rd_en are ignored.
    - after the DEPTH-1 write, go to RUN. INIT lasts exactly DEPTH cycles after rst falls.
  - RUN: ready=1; ports are serviced.
  - rst asserted mid-INIT or mid-RUN: INIT restarts from address 0. Pending writes are discarded. Memory contents are then zero after the sweep.
- Write pipeline for a write accepted in cycle t (wr_en[w]=1, state RUN):
  - Stage 1 (cycle t): read the other banks' replicas at wr_addr[w]; register addr, data and en.
  - Stage 2 (cycle t+1): bank w is written with wr_data ^ XOR(other banks' values at that address).
- Feedback forwarding (mandatory):
  - If a stage-2 write to bank v targets the same address a stage-1 feedback read of bank v is using, the stage-2 write value replaces the RAM output.
  - This makes back-to-back writes to one address from different ports correct.
- Write conflict:
  - Two or more wr_en set in the same cycle with equal wr_addr: only the highest-index port is performed; the lower-index requests are dropped.
  - wr_conflict=1 in cycle t+1; otherwise 0.
  - A same-port repeat to one address in consecutive cycles is legal and is not a conflict.
- Read:
  - rd_en[r] at cycle t in RUN gives rd_data[r] = XOR of all banks at rd_addr[r], with rd_valid[r]=1 in cycle t+1. Latency is 1.
  - If rd_en=0 or the state is not RUN: rd_valid=0 and rd_data holds its previous value.
- Read-after-write visibility (without bypass):
  - A write accepted in cycle t is visible to reads issued in cycle t+2 or later.
  - A read issued in cycle t or t+1 returns the old value.
- Multiple reads of the same address in the same cycle return identical data.
- A read and a write to different addresses in the same cycle do not interact.

Optional Feature:
- Macro: XOR_MPM_RW_BYPASS_EN.
- Defined:
  - a read issued in cycle t+1 whose rd_addr matches a stage-2 write (accepted in cycle t) returns the new logical value. That value is the XOR of the stage-2 write value with the other banks' current values.
  - Effective read-after-write distance is 1 cycle.
  - Same-cycle read and write (both at cycle t) still return the old value.
- Undefined: no read bypass logic; visibility distance is 2 cycles as stated above.

Test Plan:
- Reset, DEPTH=16: rst high 2 cycles, then low → ready=0 for exactly 16 cycles then 1; afterwards reading every address → 0 with rd_valid=1 one cycle after rd_en.
- Port0 writes A=3 D=0x5A, port1 writes A=7 D=0xC3 in the same cycle; both read ports read 3 and 7 two cycles later → 0x5A and 0xC3.
- Port0 writes A=4 D=0x11 at cycle t, port1 writes A=4 D=0x22 at t+1, read A=4 at t+3 → 0x22 (exercises feedback forwarding).
- Both ports write A=9 (port0 0xAA, port1 0xBB) in the same cycle → wr_conflict=1 for one cycle; a later read of A=9 → 0xBB.
- Write A=5 D=0x77 at cycle t, read A=5 at t+1 → 0x77 with XOR_MPM_RW_BYPASS_EN, old value (0x00) without; a read at t+2 → 0x77 in both builds.
- Assert rst mid-INIT at counter=8 and again in RUN after writes → INIT restarts; ready low for DEPTH cycles; all reads return 0 afterwards.
